fp_mul_scheduler: RTL and testbench
===================================

# fp_mul_scheduler

Round-robin scheduler that shares one pipelined single-precision floating-point multiplier (`Floatingmul`) among `N_REQ` requesters in the JPEG datapath, such as the DCT coefficient and quantisation stages. It accepts operand pairs through per-requester valid/ready handshakes and issues at most one pair per cycle to the multiplier. A tag pipeline matched to the multiplier latency returns each product to the requester that issued it.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `MUL_LAT`, default 1: clock edges between operands appearing on `mul_a`/`mul_b` and the matching product on `mul_out`. Range 0..7; 0 means the multiplier is combinational.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in `N_REQ`: requester i has an operand pair pending.
- `req_a` in 32*`N_REQ`: IEEE-754 operand A. Requester i uses bits [32i+31:32i].
- `req_b` in 32*`N_REQ`: IEEE-754 operand B, packed the same way as `req_a`.
- `req_ready` out `N_REQ`: one-hot grant. A transfer occurs on a rising edge when `req_valid[i] & req_ready[i]`.
- `mul_a` out 32: operand A to the multiplier (registered).
- `mul_b` out 32: operand B to the multiplier (registered).
- `mul_out` in 32: product from the multiplier.
- `rsp_valid` out `N_REQ`: one-hot, one-cycle pulse marking the product for requester i.
- `rsp_data` out 32: product, valid while any `rsp_valid` bit is high.
- `busy` out 1: at least one operation is in flight.

## Operation
- Round-robin pointer `ptr`, 0..`N_REQ`-1.
  - Grant goes to the first i with `req_valid[i]=1`, searching from `ptr` upward and wrapping modulo `N_REQ`.
  - `req_ready` is combinational from `req_valid` and `ptr`, and is all-zero when no request is valid.
  - Requesters must not make `req_valid` depend on `req_ready`.
- On an accepted transfer from requester g:
  - `mul_a`/`mul_b` are loaded with `req_a[g]`/`req_b[g]`.
  - `ptr` becomes (g+1) mod `N_REQ`.
  - Tag {valid=1, id=g} enters stage 0 of the tag pipeline.
- With no transfer, `ptr`, `mul_a` and `mul_b` hold their values, and an invalid tag enters stage 0.
- The tag pipeline has `MUL_LAT`+1 stages and shifts every cycle with no stall.
  - When the last stage holds a valid tag with id g, the next edge captures `rsp_data` <= `mul_out` and sets `rsp_valid` to one-hot g.
  - Otherwise that edge clears `rsp_valid` to 0, and `rsp_data` holds its value.
- Responses have no backpressure. A requester must be able to take a `rsp_valid` pulse on any cycle.
- Results are returned in issue order. Requesters may have any number of operations in flight.
- `busy` is the OR of the valid bits across all tag stages, registered.
- A lone active requester is granted every cycle, giving full throughput of one multiply per cycle.
- Arithmetic is performed entirely by the multiplier. This block passes operands and results through unmodified, with no rounding or width change.

## Timing
- Reset, asynchronous on `rst_n`=0:
  - `ptr`=0, all tags invalid.
  - `mul_a`=0, `mul_b`=0.
  - `rsp_valid`=0, `rsp_data`=0, `busy`=0.
  - `req_ready`=0 while `rst_n`=0.
- Latency: a transfer accepted at edge t produces its `rsp_valid` pulse in the cycle after edge t+`MUL_LAT`+1. This is 2 cycles for `MUL_LAT`=1.
- `busy` goes high after edge t+1 and falls one cycle after the last tag leaves the pipeline.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` is produced for them after `rst_n` rises.
- Back-to-back: an issue can occur on the same edge that a response is captured. These two paths are independent.
- Pointer wrap: a grant to requester `N_REQ`-1 sets `ptr`=0.

## Test plan
- **Single multiply.** With `MUL_LAT`=1, requester 0 issues A=0x42C80000 (100.0) and B=0x429E0000 (79.0).
  - `rsp_valid`=4'b0001 and `rsp_data`=0x45F6E000 (7900.0), exactly 2 cycles after acceptance.
- **Back-to-back products.** Requester 2 issues 0x41B80000×0x41880000 (23×17), then on the following cycle 100×79.
  - Consecutive responses to requester 2: 0x43C38000, then 0x45F6E000.
- **Full contention.** All four requesters hold `req_valid` high for 8 cycles.
  - Grants occur in the order 0,1,2,3,0,1,2,3.
  - Responses arrive in the same order, each carrying the correct id and product.
- **Fairness from a non-zero pointer.** With `ptr`=2, only requesters 1 and 3 are valid.
  - Requester 3 is granted first, then requester 1, after which `ptr`=2.
- **Reset mid-flight.** With 2 operations in flight, pulse `rst_n` low for 1 cycle.
  - No `rsp_valid` appears afterwards.
  - `ptr`=0, `busy`=0, and `mul_a`=`mul_b`=0.
- **Idle.** `req_valid`=0 for 10 cycles.
  - `req_ready`=0, `mul_a`/`mul_b` unchanged, `rsp_valid`=0, and `busy`=0 once the pipeline drains.

Source files
------------

// File: rtl/fp_mul_scheduler.sv
// Round-robin arbiter sharing one pipelined FP multiplier among N_REQ requesters.
// A tag pipeline matched to MUL_LAT steers each product back to its issuer.
module fp_mul_scheduler #(
  parameter int N_REQ   = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [31:0]           mul_a,
  output logic [31:0]           mul_b,
  input  logic [31:0]           mul_out,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int NS = MUL_LAT + 1;

  logic [PW-1:0]    r_ptr;
  logic [NS-1:0]    r_tagValid;
  logic [PW-1:0]    r_tagId [NS];

  logic             w_xfer;
  logic [PW-1:0]    w_gid;
  logic [PW-1:0]    w_ptrNext;
  logic [N_REQ-1:0] w_grant;
  logic [N_REQ-1:0] w_rspOneHot;
  int               w_idx;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    w_grant = '0;
    w_gid   = '0;
    w_xfer  = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_xfer && req_valid[w_idx]) begin
        w_xfer = 1'b1;
        w_gid  = w_idx[PW-1:0];
      end
    end
    if (w_xfer) begin
      w_grant[w_gid] = 1'b1;
    end
  end

  assign req_ready = w_grant & {N_REQ{rst_n}};
  assign w_ptrNext = (w_gid == PW'(N_REQ - 1)) ? '0 : w_gid + PW'(1);

  always_comb begin
    w_rspOneHot = '0;
    w_rspOneHot[r_tagId[NS-1]] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptrNext;
      mul_a <= req_a[32*w_gid +: 32];
      mul_b <= req_b[32*w_gid +: 32];
    end
  end

  // Tags shift every cycle; the multiplier cannot stall so neither can they.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tagValid <= '0;
      for (int i = 0; i < NS; i++) begin
        r_tagId[i] <= '0;
      end
    end else begin
      r_tagValid[0] <= w_xfer;
      r_tagId[0]    <= w_gid;
      for (int i = 1; i < NS; i++) begin
        r_tagValid[i] <= r_tagValid[i-1];
        r_tagId[i]    <= r_tagId[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
      busy      <= 1'b0;
    end else begin
      busy <= |r_tagValid;
      if (r_tagValid[NS-1]) begin
        rsp_valid <= w_rspOneHot;
        rsp_data  <= mul_out;
      end else begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Bench for fp_mul_scheduler: a one-stage FP multiplier model, a response
// scoreboard, a vector table of single multiplies and hand-written corner sequences.
module tb_fp_mul_scheduler;

  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]  req_ready;
  logic [31:0]   mul_a;
  logic [31:0]   mul_b;
  logic [31:0]   mulOut;
  logic [N-1:0]  rsp_valid;
  logic [31:0]   rsp_data;
  logic          busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] oneHot;
    logic [31:0]  data;
    int           cyc;
  } sb_t;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] prod;
  } vec_t;

  sb_t  sbQ[$];
  int   grantLog[$];
  vec_t vecs[4];

  fp_mul_scheduler #(.N_REQ(N), .MUL_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_out(mulOut),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Normal-number multiply with truncation; exact for the directed operands.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    logic [8:0]  e;
    logic        s;
    s = a[31] ^ b[31];
    p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = 9'(a[30:23]) + 9'(b[30:23]) - 9'd127;
    if (p[47]) return {s, 8'(e + 9'd1), p[46:24]};
    else       return {s, e[7:0], p[45:23]};
  endfunction

  function automatic logic [31:0] randFloat();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction

  always @(posedge clk) mulOut <= fmul(mul_a, mul_b);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic [32*N-1:0] a,
                               input logic [32*N-1:0] b);
    req_valid = v;
    req_a     = a;
    req_b     = b;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: transfers push expected responses, rsp_valid pulses pop them.
  always @(negedge clk) begin
    sb_t e;
    int  g;
    if (!rst_n) begin
      sbQ.delete();
    end else begin
      if (rsp_valid != '0) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_rsp", 64'(rsp_valid), 64'(0));
        end else begin
          e = sbQ.pop_front();
          checkOutput("sb_rsp_id", 64'(rsp_valid), 64'(e.oneHot));
          checkOutput("sb_rsp_data", 64'(rsp_data), 64'(e.data));
          checkOutput("sb_rsp_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if ((req_valid & req_ready) != '0) begin
        g = 0;
        for (int i = 0; i < N; i++) if (req_valid[i] & req_ready[i]) g = i;
        e.oneHot = N'(1) << g;
        e.data   = fmul(req_a[32*g +: 32], req_b[32*g +: 32]);
        e.cyc    = cyc + 3;
        sbQ.push_back(e);
        grantLog.push_back(g);
      end
    end
  end

  initial begin
    logic [32*N-1:0] aBus;
    logic [32*N-1:0] bBus;

    vecs[0] = '{0, 32'h42C80000, 32'h429E0000, 32'h45F6E000};
    vecs[1] = '{2, 32'h41B80000, 32'h41880000, 32'h43C38000};
    vecs[2] = '{1, 32'h3FC00000, 32'hC0000000, 32'hC0400000};
    vecs[3] = '{3, 32'h40400000, 32'h3F000000, 32'h3FC00000};

    rst_n = 1'b0;
    applyStimulus('1, '0, '0);
    @(negedge clk);
    checkOutput("reset_ready", 64'(req_ready), 64'(0));
    checkOutput("reset_mul_a", 64'(mul_a), 64'(0));
    checkOutput("reset_mul_b", 64'(mul_b), 64'(0));
    checkOutput("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    checkOutput("reset_rsp_data", 64'(rsp_data), 64'(0));
    checkOutput("reset_busy", 64'(busy), 64'(0));
    nextCycle();
    applyStimulus('0, '0, '0);
    rst_n = 1'b1;
    nextCycle();

    // Single multiplies with exact latency and busy timing.
    for (int v = 0; v < 4; v++) begin
      aBus = '0;
      bBus = '0;
      aBus[32*vecs[v].id +: 32] = vecs[v].a;
      bBus[32*vecs[v].id +: 32] = vecs[v].b;
      applyStimulus(N'(1) << vecs[v].id, aBus, bBus);
      @(negedge clk);
      checkOutput("single_ready", 64'(req_ready), 64'(N'(1) << vecs[v].id));
      nextCycle();
      applyStimulus('0, '0, '0);
      checkOutput("single_mul_a", 64'(mul_a), 64'(vecs[v].a));
      checkOutput("single_mul_b", 64'(mul_b), 64'(vecs[v].b));
      @(negedge clk);
      checkOutput("single_busy_t0", 64'(busy), 64'(0));
      @(posedge clk); @(negedge clk);
      checkOutput("single_busy_t1", 64'(busy), 64'(1));
      checkOutput("single_early_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk); @(negedge clk);
      checkOutput("single_rsp_valid", 64'(rsp_valid), 64'(N'(1) << vecs[v].id));
      checkOutput("single_rsp_data", 64'(rsp_data), 64'(vecs[v].prod));
      @(posedge clk); @(negedge clk);
      checkOutput("single_rsp_clear", 64'(rsp_valid), 64'(0));
      checkOutput("single_rsp_hold", 64'(rsp_data), 64'(vecs[v].prod));
      checkOutput("single_busy_end", 64'(busy), 64'(0));
      nextCycle();
    end

    // Full contention from ptr=0: eight grants in rotation.
    grantLog.delete();
    for (int i = 0; i < N; i++) begin
      aBus[32*i +: 32] = randFloat();
      bBus[32*i +: 32] = randFloat();
    end
    applyStimulus('1, aBus, bBus);
    for (int c = 0; c < 8; c++) begin
      nextCycle();
      for (int i = 0; i < N; i++) begin
        aBus[32*i +: 32] = randFloat();
        bBus[32*i +: 32] = randFloat();
      end
      applyStimulus((c < 7) ? '1 : '0, aBus, bBus);
    end
    repeat (4) nextCycle();
    checkOutput("contention_grants", 64'(grantLog.size()), 64'(8));
    for (int i = 0; i < grantLog.size(); i++) begin
      checkOutput("contention_order", 64'(grantLog[i]), 64'(i % N));
    end

    // Back-to-back issues from requester 2.
    aBus = '0; bBus = '0;
    aBus[64 +: 32] = 32'h41B80000; bBus[64 +: 32] = 32'h41880000;
    applyStimulus(4'b0100, aBus, bBus);
    nextCycle();
    aBus[64 +: 32] = 32'h42C80000; bBus[64 +: 32] = 32'h429E0000;
    applyStimulus(4'b0100, aBus, bBus);
    nextCycle();
    applyStimulus('0, '0, '0);
    @(negedge clk);
    checkOutput("b2b_none_yet", 64'(rsp_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    checkOutput("b2b_first_id", 64'(rsp_valid), 64'(4'b0100));
    checkOutput("b2b_first_data", 64'(rsp_data), 64'(32'h43C38000));
    @(posedge clk); @(negedge clk);
    checkOutput("b2b_second_id", 64'(rsp_valid), 64'(4'b0100));
    checkOutput("b2b_second_data", 64'(rsp_data), 64'(32'h45F6E000));
    repeat (3) nextCycle();

    // Move ptr to 2, then only requesters 1 and 3 compete.
    aBus = {4{32'h3F800000}}; bBus = {4{32'h40400000}};
    applyStimulus(4'b0010, aBus, bBus);
    nextCycle();
    grantLog.delete();
    applyStimulus(4'b1010, aBus, bBus);
    @(negedge clk);
    checkOutput("fair_first_ready", 64'(req_ready), 64'(4'b1000));
    nextCycle();
    @(negedge clk);
    checkOutput("fair_second_ready", 64'(req_ready), 64'(4'b0010));
    nextCycle();
    applyStimulus('1, aBus, bBus);
    @(negedge clk);
    checkOutput("fair_ptr_is_2", 64'(req_ready), 64'(4'b0100));
    nextCycle();
    applyStimulus('0, '0, '0);
    checkOutput("fair_log_size", 64'(grantLog.size()), 64'(3));
    if (grantLog.size() >= 2) begin
      checkOutput("fair_log0", 64'(grantLog[0]), 64'(3));
      checkOutput("fair_log1", 64'(grantLog[1]), 64'(1));
    end
    repeat (4) nextCycle();

    // Reset with two operations in flight.
    aBus = {4{32'h40000000}}; bBus = {4{32'h40000000}};
    applyStimulus(4'b0001, aBus, bBus);
    nextCycle();
    nextCycle();
    rst_n = 1'b0;
    applyStimulus('1, aBus, bBus);
    @(negedge clk);
    checkOutput("midrst_ready", 64'(req_ready), 64'(0));
    checkOutput("midrst_busy", 64'(busy), 64'(0));
    checkOutput("midrst_mul_a", 64'(mul_a), 64'(0));
    nextCycle();
    applyStimulus('0, '0, '0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("midrst_no_rsp", 64'(rsp_valid), 64'(0));
      @(posedge clk);
    end
    #1;
    checkOutput("midrst_mul_a_after", 64'(mul_a), 64'(0));
    checkOutput("midrst_mul_b_after", 64'(mul_b), 64'(0));
    checkOutput("midrst_busy_after", 64'(busy), 64'(0));
    aBus = {4{32'h3F800000}}; bBus = {4{32'h40000000}};
    applyStimulus('1, aBus, bBus);
    @(negedge clk);
    checkOutput("midrst_ptr_zero", 64'(req_ready), 64'(4'b0001));
    nextCycle();
    applyStimulus('0, aBus, bBus);

    // Idle: operands hold, nothing granted, pipeline drains.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checkOutput("idle_ready", 64'(req_ready), 64'(0));
      checkOutput("idle_mul_a", 64'(mul_a), 64'(32'h3F800000));
      checkOutput("idle_mul_b", 64'(mul_b), 64'(32'h40000000));
      if (c >= 3) begin
        checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'(0));
        checkOutput("idle_busy", 64'(busy), 64'(0));
      end
      @(posedge clk);
    end

    checkOutput("sb_drained", 64'(sbQ.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
